// File: rtl/sht40_meas_scheduler.sv
// rtl/sht40_meas_scheduler.sv - SHT40 measurement trigger, retry and sample capture sequencer
module sht40_meas_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [6:0]  ADDR           = 7'h44
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        oneshot,
  input  logic [1:0]  mode,
  input  logic        busy_i,
  input  logic        crc_err_i,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        start,
  output logic [7:0]  cmd,
  output logic [6:0]  addr,
  output logic [15:0] temp_out,
  output logic [15:0] rh_out,
  output logic        sample_valid,
  output logic        overrun,
  output logic        fault,
  output logic [7:0]  err_count
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETRY, S_DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    retry_cnt;
  logic          pending, pending_n, enable_q, word_idx;
  logic [15:0]   temp_shadow, rh_shadow;
  logic          wrap, trig, take, en_fall, handshake, fail, can_retry;

  function automatic logic [7:0] mode_cmd(input logic [1:0] m);
    case (m)
      2'b00:   mode_cmd = 8'hE0;
      2'b01:   mode_cmd = 8'hF6;
      default: mode_cmd = 8'hFD;
    endcase
  endfunction

  assign addr      = ADDR;
  assign wrap      = enable && (period_cnt == PW'(PERIOD_CYCLES - 1));
  assign trig      = wrap || oneshot;
  assign take      = (state == S_IDLE) && pending && !busy_i;
  // Only a falling enable drops a queued trigger, so a oneshot still works while disabled.
  assign en_fall   = enable_q && !enable;
  assign handshake = s_axis_tvalid && s_axis_tready;
  assign fail      = (state == S_WAIT) && (crc_err_i || (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)));
  assign can_retry = retry_cnt < 4'(MAX_RETRIES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    if (en_fall || take) pending_n = 1'b0;
    if (trig)            pending_n = 1'b1;
    case (state)
      S_IDLE:  if (take) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (fail)                       state_n = can_retry ? S_RETRY : S_IDLE;
        else if (handshake && word_idx) state_n = S_DONE;
      end
      S_RETRY: if (!busy_i) state_n = S_ISSUE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt    <= '0;
      tmo_cnt       <= '0;
      retry_cnt     <= '0;
      pending       <= 1'b0;
      enable_q      <= 1'b0;
      word_idx      <= 1'b0;
      temp_shadow   <= '0;
      rh_shadow     <= '0;
      cmd           <= 8'hFD;
      temp_out      <= '0;
      rh_out        <= '0;
      err_count     <= '0;
      start         <= 1'b0;
      s_axis_tready <= 1'b0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
      fault         <= 1'b0;
    end else begin
      enable_q      <= enable;
      period_cnt    <= (!enable || wrap) ? '0 : period_cnt + PW'(1);
      pending       <= pending_n;
      overrun       <= trig && pending && !take && !en_fall;
      start         <= (state_n == S_ISSUE);
      s_axis_tready <= (state_n == S_WAIT);
      sample_valid  <= (state == S_DONE);
      fault         <= fail && !can_retry;
      if (take) begin
        cmd       <= mode_cmd(mode);
        retry_cnt <= '0;
      end
      if (state == S_ISSUE) begin
        tmo_cnt  <= '0;
        word_idx <= 1'b0;
      end
      if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        // A CRC error outranks a coincident second word: the sample is dropped.
        if (fail) begin
          word_idx <= 1'b0;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          if (can_retry)          retry_cnt <= retry_cnt + 4'd1;
        end else if (handshake) begin
          if (!word_idx) begin
            temp_shadow <= s_axis_tdata;
            word_idx    <= 1'b1;
          end else begin
            rh_shadow <= s_axis_tdata;
          end
        end
      end
      if (state == S_DONE) begin
        temp_out <= temp_shadow;
        rh_out   <= rh_shadow;
      end
    end
  end

endmodule

// File: tb/tb_sht40_meas_scheduler.sv
// tb/tb_sht40_meas_scheduler.sv - directed self-checking bench for sht40_meas_scheduler
module tb_sht40_meas_scheduler;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, oneshot = 1'b0;
  logic        busy_i = 1'b0, crc_err_i = 1'b0, s_axis_tvalid = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] s_axis_tdata = 16'h0;
  logic        s_axis_tready, start, sample_valid, overrun, fault;
  logic [7:0]  cmd, err_count;
  logic [6:0]  addr;
  logic [15:0] temp_out, rh_out;

  always #5 clk = ~clk;

  sht40_meas_scheduler #(
    .PERIOD_CYCLES(1000), .TIMEOUT_CYCLES(200), .MAX_RETRIES(2), .ADDR(7'h44)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .oneshot(oneshot), .mode(mode),
    .busy_i(busy_i), .crc_err_i(crc_err_i), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .start(start),
    .cmd(cmd), .addr(addr), .temp_out(temp_out), .rh_out(rh_out),
    .sample_valid(sample_valid), .overrun(overrun), .fault(fault), .err_count(err_count)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] t;
    logic [15:0] h;
    logic [7:0]  cmd;
  } vec_t;

  vec_t vecs[4];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0, n_start = 0, n_sv = 0, n_ovr = 0, n_fault = 0, fault_cyc = -1;
  int   s0, v0, o0, f0, c0;
  int   start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qget(input int k);
    return (k < start_q.size()) ? start_q[k] : -1;
  endfunction

  // Advance one clock and log output pulses, sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (start) begin
      n_start++;
      start_q.push_back(cyc);
    end
    if (sample_valid) n_sv++;
    if (overrun) n_ovr++;
    if (fault) begin
      n_fault++;
      fault_cyc = cyc;
    end
  endtask

  // Prompt word source: offers w0 then w1 whenever tready is high; crc_hs selects a handshake to corrupt.
  task automatic serve(input int ncyc, input logic [15:0] w0, input logic [15:0] w1, input int crc_hs);
    int   widx;
    int   hs;
    logic rdy;
    widx = 0;
    hs   = 0;
    for (int i = 0; i < ncyc; i++) begin
      rdy           = s_axis_tready;
      s_axis_tvalid = rdy;
      s_axis_tdata  = (widx == 0) ? w0 : w1;
      crc_err_i     = rdy && (hs == crc_hs);
      tick();
      if (rdy) begin
        widx = (crc_err_i || widx == 1) ? 0 : 1;
        hs++;
      end
    end
    s_axis_tvalid = 1'b0;
    crc_err_i     = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 16'h6666, 16'h8000, 8'hE0};
    vecs[1] = '{2'b01, 16'h1234, 16'hABCD, 8'hF6};
    vecs[2] = '{2'b10, 16'h0000, 16'hFFFF, 8'hFD};
    vecs[3] = '{2'b11, 16'hFFFF, 16'h0001, 8'hFD};

    tick();
    tick();
    check("rst_start", start, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fault", fault, 0);
    check("rst_temp", temp_out, 0);
    check("rst_rh", rh_out, 0);
    check("rst_err", err_count, 0);
    check("rst_cmd", cmd, 8'hFD);
    check("rst_addr", addr, 7'h44);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      s0 = n_start;
      v0 = n_sv;
      mode = vecs[i].mode;
      oneshot = 1'b1;
      tick();
      oneshot = 1'b0;
      check("tbl_start_early", start, 0);
      tick();
      check("tbl_start_at_2", start, 1);
      check("tbl_cmd", cmd, vecs[i].cmd);
      check("tbl_addr", addr, 7'h44);
      mode = ~vecs[i].mode;
      serve(8, vecs[i].t, vecs[i].h, -1);
      check("tbl_temp", temp_out, vecs[i].t);
      check("tbl_rh", rh_out, vecs[i].h);
      check("tbl_sv_count", n_sv - v0, 1);
      check("tbl_start_count", n_start - s0, 1);
      check("tbl_cmd_held", cmd, vecs[i].cmd);
    end

    s0 = start_q.size();
    v0 = n_sv;
    o0 = n_ovr;
    c0 = cyc;
    enable = 1'b1;
    serve(3500, 16'hA5A5, 16'h5A5A, -1);
    enable = 1'b0;
    check("per_starts", start_q.size() - s0, 3);
    check("per_start1", qget(s0) - c0, 1001);
    check("per_start2", qget(s0 + 1) - c0, 2001);
    check("per_start3", qget(s0 + 2) - c0, 3001);
    check("per_sv", n_sv - v0, 3);
    check("per_overrun", n_ovr - o0, 0);
    check("per_temp", temp_out, 16'hA5A5);
    tick();

    s0 = start_q.size();
    f0 = n_fault;
    v0 = n_sv;
    c0 = cyc;
    oneshot = 1'b1;
    tick();
    oneshot = 1'b0;
    for (int i = 0; i < 700; i++) tick();
    check("to_starts", start_q.size() - s0, 3);
    check("to_start1", qget(s0) - c0, 2);
    check("to_gap1", qget(s0 + 1) - qget(s0), 202);
    check("to_gap2", qget(s0 + 2) - qget(s0 + 1), 202);
    check("to_faults", n_fault - f0, 1);
    check("to_fault_time", fault_cyc - qget(s0 + 2), 201);
    check("to_err", err_count, 3);
    check("to_sv", n_sv - v0, 0);
    check("to_temp_kept", temp_out, 16'hA5A5);
    check("to_rh_kept", rh_out, 16'h5A5A);
    check("to_idle_tready", s_axis_tready, 0);

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    s0 = n_start;
    v0 = n_sv;
    f0 = n_fault;
    oneshot = 1'b1;
    tick();
    oneshot = 1'b0;
    tick();
    serve(30, 16'h2222, 16'h3333, 0);
    check("crc1_err", err_count, 1);
    check("crc1_starts", n_start - s0, 2);
    check("crc1_sv", n_sv - v0, 1);
    check("crc1_fault", n_fault - f0, 0);
    check("crc1_temp", temp_out, 16'h2222);
    check("crc1_rh", rh_out, 16'h3333);

    s0 = n_start;
    v0 = n_sv;
    oneshot = 1'b1;
    tick();
    oneshot = 1'b0;
    tick();
    serve(30, 16'h4444, 16'h5555, 1);
    check("crc2_err", err_count, 2);
    check("crc2_starts", n_start - s0, 2);
    check("crc2_sv", n_sv - v0, 1);
    check("crc2_temp", temp_out, 16'h4444);
    check("crc2_rh", rh_out, 16'h5555);

    busy_i = 1'b1;
    s0 = n_start;
    o0 = n_ovr;
    for (int k = 0; k < 3; k++) begin
      oneshot = 1'b1;
      tick();
      oneshot = 1'b0;
      tick();
      tick();
    end
    for (int i = 0; i < 10; i++) tick();
    check("busy_overrun", n_ovr - o0, 2);
    check("busy_no_start", n_start - s0, 0);
    busy_i = 1'b0;
    serve(12, 16'h7777, 16'h8888, -1);
    check("busy_release_start", n_start - s0, 1);
    check("busy_release_temp", temp_out, 16'h7777);

    oneshot = 1'b1;
    tick();
    oneshot = 1'b0;
    tick();
    tick();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'h9999;
    tick();
    s_axis_tvalid = 1'b0;
    check("mid_wait_tready", s_axis_tready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tready", s_axis_tready, 0);
    check("mid_rst_start", start, 0);
    check("mid_rst_temp", temp_out, 0);
    check("mid_rst_rh", rh_out, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_cmd", cmd, 8'hFD);
    check("mid_rst_sv", sample_valid, 0);
    check("mid_rst_fault", fault, 0);
    tick();
    tick();
    rst_n = 1'b1;
    s0 = n_start;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_no_start", n_start - s0, 0);
    mode = 2'b01;
    oneshot = 1'b1;
    tick();
    oneshot = 1'b0;
    tick();
    check("post_rst_start", start, 1);
    check("post_rst_cmd", cmd, 8'hF6);
    serve(8, 16'hBBBB, 16'hCCCC, -1);
    check("post_rst_temp", temp_out, 16'hBBBB);
    check("post_rst_rh", rh_out, 16'hCCCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
